// File: rtl/cmp_wb_collector_pkg.sv
// Shared definitions for the CMP write-back collector.
// Holds the node/record widths, the record layout that flows from the per-node
// FIFOs to the output register, and the address-window test used at capture.
package cmp_wb_collector_pkg;

   localparam int DATA_WIDTH    = 64;
   localparam int ADDR_WIDTH    = 32;
   localparam int NODE_ID_WIDTH = 2;
   localparam int NUM_NODES     = 4;

   // One captured store: which node issued it, where it went, what was written.
   typedef struct packed {
      logic [NODE_ID_WIDTH-1:0] node;
      logic [ADDR_WIDTH-1:0]    addr;
      logic [DATA_WIDTH-1:0]    data;
   } wb_rec_t;

   localparam int REC_WIDTH = $bits(wb_rec_t);

   // Inclusive unsigned window test.
   function automatic logic inWindow(input logic [ADDR_WIDTH-1:0] addr,
                                     input logic [ADDR_WIDTH-1:0] base,
                                     input logic [ADDR_WIDTH-1:0] limit);
      return (addr >= base) && (addr <= limit);
   endfunction

endpackage

// File: rtl/cmp_wb_fifo.sv
// Single-clock synchronous FIFO used once per snooped node.
// Ports:
//   clk, reset        clock and asynchronous active-low reset
//   push_i, wdata_i   enqueue request and data (ignored when full unless popping)
//   pop_i, rdata_o    dequeue request; rdata_o always shows the head entry
//   full_o, empty_o   occupancy flags
//   count_o           number of stored entries (0..DEPTH)
// A push and a pop in the same cycle on a full FIFO both take effect.
module cmp_wb_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push_i,
   input  logic                     pop_i,
   input  logic [WIDTH-1:0]         wdata_i,
   output logic [WIDTH-1:0]         rdata_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
   localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
   localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
   logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
   logic [PTR_W:0]   count_q, count_d;
   logic             doPush;
   logic             doPop;

   assign full_o  = (count_q == CNT_FULL);
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign rdata_o = mem_q[rdPtr_q];

   // A pop frees the slot the push needs, so a full FIFO still accepts a push
   // when it is being popped in the same cycle.
   assign doPop  = pop_i && !empty_o;
   assign doPush = push_i && (!full_o || doPop);

   always_comb begin
      wrPtr_d = wrPtr_q;
      rdPtr_d = rdPtr_q;
      count_d = count_q;
      if (doPush) begin
         wrPtr_d = wrPtr_q + PTR_ONE;
      end
      if (doPop) begin
         rdPtr_d = rdPtr_q + PTR_ONE;
      end
      if (doPush && !doPop) begin
         count_d = count_q + CNT_ONE;
      end else if (doPop && !doPush) begin
         count_d = count_q - CNT_ONE;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wrPtr_q <= '0;
         rdPtr_q <= '0;
         count_q <= '0;
      end else begin
         wrPtr_q <= wrPtr_d;
         rdPtr_q <= rdPtr_d;
         count_q <= count_d;
      end
   end

   // Storage needs no reset: the pointers decide what is valid.
   always_ff @(posedge clk) begin
      if (doPush) begin
         mem_q[wrPtr_q] <= wdata_i;
      end
   end

endmodule

// File: rtl/cmp_wb_collector.sv
// Non-intrusive write-back collector for a 4-core CMP.
// Snoops each node's data-memory write port, captures stores whose address
// lies in [WIN_BASE, WIN_LIMIT] into a per-node FIFO, and drains the FIFOs
// round-robin into one registered valid/ready record stream.
// Ports:
//   clk, reset                 clock and asynchronous active-low reset
//   nodeN_memEn/_memWrEn       node N memory enable / write enable (N=0..3)
//   nodeN_addr/_d              node N address / store data
//   out_valid/out_ready        record stream handshake
//   out_node/out_addr/out_data record contents
//   ovf                        sticky per-node overflow flags
//   cap_cnt                    saturating count of captured records
module cmp_wb_collector
   import cmp_wb_collector_pkg::*;
#(
   parameter int                    FIFO_DEPTH = 4,
   parameter logic [ADDR_WIDTH-1:0] WIN_BASE   = 32'h0000_C000,
   parameter logic [ADDR_WIDTH-1:0] WIN_LIMIT  = 32'h0000_FFFF
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     node0_memEn,
   input  logic                     node0_memWrEn,
   input  logic [ADDR_WIDTH-1:0]    node0_addr,
   input  logic [DATA_WIDTH-1:0]    node0_d,
   input  logic                     node1_memEn,
   input  logic                     node1_memWrEn,
   input  logic [ADDR_WIDTH-1:0]    node1_addr,
   input  logic [DATA_WIDTH-1:0]    node1_d,
   input  logic                     node2_memEn,
   input  logic                     node2_memWrEn,
   input  logic [ADDR_WIDTH-1:0]    node2_addr,
   input  logic [DATA_WIDTH-1:0]    node2_d,
   input  logic                     node3_memEn,
   input  logic                     node3_memWrEn,
   input  logic [ADDR_WIDTH-1:0]    node3_addr,
   input  logic [DATA_WIDTH-1:0]    node3_d,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [NODE_ID_WIDTH-1:0] out_node,
   output logic [ADDR_WIDTH-1:0]    out_addr,
   output logic [DATA_WIDTH-1:0]    out_data,
   output logic [NUM_NODES-1:0]     ovf,
   output logic [15:0]              cap_cnt
);

   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

   logic [NUM_NODES-1:0]     memEn;
   logic [NUM_NODES-1:0]     memWrEn;
   logic [ADDR_WIDTH-1:0]    nodeAddr [NUM_NODES];
   logic [DATA_WIDTH-1:0]    nodeData [NUM_NODES];

   logic [NUM_NODES-1:0]     capture;
   logic [NUM_NODES-1:0]     enq;
   logic [NUM_NODES-1:0]     pop;
   logic [NUM_NODES-1:0]     fifoFull;
   logic [NUM_NODES-1:0]     fifoEmpty;
   logic [NUM_NODES-1:0]     unusedCount;
   wb_rec_t                  pushRec  [NUM_NODES];
   wb_rec_t                  headRec  [NUM_NODES];
   logic [CNT_W-1:0]         fifoCount [NUM_NODES];

   logic                     load;
   logic                     grantFound;
   logic [NODE_ID_WIDTH-1:0] grantNode;
   logic [NODE_ID_WIDTH-1:0] searchIdx;
   logic [2:0]               enqSum;
   logic [16:0]              capSum;

   logic                     outValid_q, outValid_d;
   wb_rec_t                  outRec_q,   outRec_d;
   logic [NODE_ID_WIDTH-1:0] rrPtr_q,    rrPtr_d;
   logic [NUM_NODES-1:0]     ovf_q,      ovf_d;
   logic [15:0]              capCnt_q,   capCnt_d;

   assign memEn    = {node3_memEn,   node2_memEn,   node1_memEn,   node0_memEn};
   assign memWrEn  = {node3_memWrEn, node2_memWrEn, node1_memWrEn, node0_memWrEn};
   assign nodeAddr = '{node0_addr, node1_addr, node2_addr, node3_addr};
   assign nodeData = '{node0_d,    node1_d,    node2_d,    node3_d};

   // Per-node capture filter and FIFO. A store only enters when there is room,
   // counting the slot freed by a same-cycle pop of that node.
   for (genvar n = 0; n < NUM_NODES; n++) begin : gNode
      assign capture[n] = memEn[n] && memWrEn[n] && inWindow(nodeAddr[n], WIN_BASE, WIN_LIMIT);
      assign enq[n]     = capture[n] && (!fifoFull[n] || pop[n]);
      assign pop[n]     = load && grantFound && (grantNode == NODE_ID_WIDTH'(n));
      assign pushRec[n] = '{node: NODE_ID_WIDTH'(n), addr: nodeAddr[n], data: nodeData[n]};
      assign unusedCount[n] = ^fifoCount[n];

      cmp_wb_fifo #(
         .WIDTH (REC_WIDTH),
         .DEPTH (FIFO_DEPTH)
      ) uFifo (
         .clk     (clk),
         .reset   (reset),
         .push_i  (enq[n]),
         .pop_i   (pop[n]),
         .wdata_i (pushRec[n]),
         .rdata_o (headRec[n]),
         .full_o  (fifoFull[n]),
         .empty_o (fifoEmpty[n]),
         .count_o (fifoCount[n])
      );
   end

   // Round-robin search: first non-empty FIFO at or above the pointer, wrapping.
   // Uses registered FIFO state only, so same-cycle captures are never granted.
   always_comb begin
      grantFound = 1'b0;
      grantNode  = '0;
      searchIdx  = '0;
      for (int i = 0; i < NUM_NODES; i++) begin
         searchIdx = rrPtr_q + NODE_ID_WIDTH'(i);
         if (!grantFound && !fifoEmpty[searchIdx]) begin
            grantFound = 1'b1;
            grantNode  = searchIdx;
         end
      end
   end

   // Output register refills whenever it is empty or its record is leaving;
   // otherwise the record is held stable under backpressure.
   assign load = !outValid_q || out_ready;

   always_comb begin
      outValid_d = outValid_q;
      outRec_d   = outRec_q;
      rrPtr_d    = rrPtr_q;
      if (load) begin
         if (grantFound) begin
            outValid_d = 1'b1;
            outRec_d   = headRec[grantNode];
            rrPtr_d    = grantNode + NODE_ID_WIDTH'(1);
         end else begin
            outValid_d = 1'b0;
         end
      end
   end

   // Overflow is sticky; capture count adds every accepted record and saturates.
   always_comb begin
      enqSum = '0;
      for (int i = 0; i < NUM_NODES; i++) begin
         enqSum = enqSum + {2'b00, enq[i]};
      end
      capSum   = {1'b0, capCnt_q} + {14'b0, enqSum};
      capCnt_d = capSum[16] ? 16'hFFFF : capSum[15:0];
      ovf_d    = ovf_q | (capture & ~enq);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         outValid_q <= 1'b0;
         outRec_q   <= '0;
         rrPtr_q    <= '0;
         ovf_q      <= '0;
         capCnt_q   <= '0;
      end else begin
         outValid_q <= outValid_d;
         outRec_q   <= outRec_d;
         rrPtr_q    <= rrPtr_d;
         ovf_q      <= ovf_d;
         capCnt_q   <= capCnt_d;
      end
   end

   assign out_valid = outValid_q;
   assign out_node  = outRec_q.node;
   assign out_addr  = outRec_q.addr;
   assign out_data  = outRec_q.data;
   assign ovf       = ovf_q;
   assign cap_cnt   = capCnt_q;

endmodule

// File: tb/tb_cmp_wb_collector.sv
// Self-checking bench for cmp_wb_collector: directed scenarios followed by
// random traffic, all compared every cycle against a queue-based model.
module tb_cmp_wb_collector;

   localparam int DEPTH = 4;
   localparam logic [31:0] WBASE  = 32'h0000_C000;
   localparam logic [31:0] WLIMIT = 32'h0000_FFFF;

   typedef struct packed {
      logic [1:0]  node;
      logic [31:0] addr;
      logic [63:0] data;
   } recT;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  memEn;
   logic [3:0]  memWrEn;
   logic [31:0] addr [4];
   logic [63:0] data [4];
   logic        outReady;

   logic        outValid;
   logic [1:0]  outNode;
   logic [31:0] outAddr;
   logic [63:0] outData;
   logic [3:0]  ovf;
   logic [15:0] capCnt;

   int errors = 0;
   int checks = 0;

   // Reference model state
   recT         mQ [4][$];
   bit          mValid;
   recT         mRec;
   int          mRr;
   logic [3:0]  mOvf;
   int          mCnt;

   cmp_wb_collector dut (
      .clk           (clk),
      .reset         (reset),
      .node0_memEn   (memEn[0]),
      .node0_memWrEn (memWrEn[0]),
      .node0_addr    (addr[0]),
      .node0_d       (data[0]),
      .node1_memEn   (memEn[1]),
      .node1_memWrEn (memWrEn[1]),
      .node1_addr    (addr[1]),
      .node1_d       (data[1]),
      .node2_memEn   (memEn[2]),
      .node2_memWrEn (memWrEn[2]),
      .node2_addr    (addr[2]),
      .node2_d       (data[2]),
      .node3_memEn   (memEn[3]),
      .node3_memWrEn (memWrEn[3]),
      .node3_addr    (addr[3]),
      .node3_d       (data[3]),
      .out_valid     (outValid),
      .out_ready     (outReady),
      .out_node      (outNode),
      .out_addr      (outAddr),
      .out_data      (outData),
      .ovf           (ovf),
      .cap_cnt       (capCnt)
   );

   // 10 ns clock
   always #5 clk = ~clk;

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
      end
   endtask

   task automatic modelReset();
      for (int n = 0; n < 4; n++) mQ[n].delete();
      mValid = 1'b0;
      mRec   = '0;
      mRr    = 0;
      mOvf   = '0;
      mCnt   = 0;
   endtask

   // One rising edge of the reference behaviour, using the inputs driven this cycle.
   task automatic modelStep();
      int  g;
      int  n;
      bit  load;
      recT popped;
      load   = !mValid || outReady;
      g      = -1;
      popped = '0;
      if (load) begin
         for (int i = 0; i < 4; i++) begin
            n = (mRr + i) % 4;
            if (g < 0 && mQ[n].size() > 0) g = n;
         end
      end
      if (g >= 0) popped = mQ[g].pop_front();
      for (int k = 0; k < 4; k++) begin
         if (memEn[k] && memWrEn[k] && addr[k] >= WBASE && addr[k] <= WLIMIT) begin
            if (mQ[k].size() < DEPTH) begin
               mQ[k].push_back('{node: 2'(k), addr: addr[k], data: data[k]});
               if (mCnt < 65535) mCnt++;
            end else begin
               mOvf[k] = 1'b1;
            end
         end
      end
      if (load) begin
         if (g >= 0) begin
            mValid = 1'b1;
            mRec   = popped;
            mRr    = (g + 1) % 4;
         end else begin
            mValid = 1'b0;
         end
      end
   endtask

   task automatic compareAll();
      checkOutput("out_valid", {63'b0, outValid}, {63'b0, mValid});
      checkOutput("out_node",  {62'b0, outNode},  {62'b0, mRec.node});
      checkOutput("out_addr",  {32'b0, outAddr},  {32'b0, mRec.addr});
      checkOutput("out_data",  outData,           mRec.data);
      checkOutput("ovf",       {60'b0, ovf},      {60'b0, mOvf});
      checkOutput("cap_cnt",   {48'b0, capCnt},   64'(mCnt));
   endtask

   // Inputs are set at the falling edge before calling; one clock is applied,
   // the model advances, and outputs are compared at the next falling edge.
   task automatic applyStimulus();
      @(posedge clk);
      if (reset) modelStep();
      else       modelReset();
      @(negedge clk);
      compareAll();
   endtask

   task automatic setIdle();
      memEn   = '0;
      memWrEn = '0;
      for (int n = 0; n < 4; n++) begin
         addr[n] = '0;
         data[n] = '0;
      end
   endtask

   task automatic setWrite(input int n, input logic [31:0] a, input logic [63:0] d, input bit wr);
      memEn[n]   = 1'b1;
      memWrEn[n] = wr;
      addr[n]    = a;
      data[n]    = d;
   endtask

   task automatic pulseReset();
      reset = 1'b0;
      setIdle();
      applyStimulus();
      reset = 1'b1;
   endtask

   logic [31:0] filterAddr [5];
   logic [31:0] randAddr;

   initial begin
      reset    = 1'b0;
      outReady = 1'b1;
      setIdle();
      modelReset();

      // Reset held while nodes write: nothing may be captured.
      for (int c = 0; c < 3; c++) begin
         for (int n = 0; n < 4; n++) setWrite(n, WBASE + 32'(c), 64'(c + 1), 1'b1);
         applyStimulus();
      end
      checkOutput("rst_valid", {63'b0, outValid}, 64'd0);
      checkOutput("rst_cnt",   {48'b0, capCnt},   64'd0);

      // Release, then one in-window store from node 2.
      reset = 1'b1;
      setIdle();
      applyStimulus();
      setWrite(2, 32'h0000_C000, 64'hDEAD, 1'b1);
      applyStimulus();
      checkOutput("lat_not_yet", {63'b0, outValid}, 64'd0);
      setIdle();
      applyStimulus();
      checkOutput("lat_valid", {63'b0, outValid}, 64'd1);
      checkOutput("lat_node",  {62'b0, outNode},  64'd2);
      checkOutput("lat_addr",  {32'b0, outAddr},  64'h0000_C000);
      checkOutput("lat_data",  outData,           64'hDEAD);
      checkOutput("lat_cnt",   {48'b0, capCnt},   64'd1);
      applyStimulus();

      // Window boundaries plus a read inside the window.
      filterAddr = '{32'h0000_BFFF, 32'h0000_C000, 32'h0000_FFFF, 32'h0001_0000, 32'h0000_C004};
      for (int i = 0; i < 5; i++) begin
         setIdle();
         setWrite(0, filterAddr[i], 64'(32'h100 + i), i != 4);
         applyStimulus();
      end
      setIdle();
      for (int i = 0; i < 3; i++) applyStimulus();
      checkOutput("filter_cnt", {48'b0, capCnt}, 64'd3);

      // All four nodes in one cycle, drained in node order from a fresh pointer.
      pulseReset();
      for (int n = 0; n < 4; n++) setWrite(n, WBASE + 32'(n), 64'(32'hA0 + n), 1'b1);
      applyStimulus();
      setIdle();
      for (int i = 0; i < 4; i++) begin
         applyStimulus();
         checkOutput("sim_order", {62'b0, outNode}, 64'(i));
      end
      applyStimulus();

      // Backpressure: node 1 overruns its FIFO by one.
      outReady = 1'b0;
      for (int i = 0; i < 6; i++) begin
         setIdle();
         setWrite(1, 32'h0000_C100 + 32'(i), 64'(32'h200 + i), 1'b1);
         applyStimulus();
      end
      setIdle();
      applyStimulus();
      checkOutput("ovf_node1", {60'b0, ovf}, 64'b0010);
      checkOutput("bp_hold",   outData,      64'h200);
      outReady = 1'b1;
      for (int i = 0; i < 7; i++) applyStimulus();

      // Two nodes writing continuously share the output fairly.
      for (int i = 0; i < 8; i++) begin
         setIdle();
         setWrite(0, 32'h0000_D000 + 32'(i), 64'(32'h300 + i), 1'b1);
         setWrite(3, 32'h0000_E000 + 32'(i), 64'(32'h400 + i), 1'b1);
         applyStimulus();
      end
      setIdle();
      for (int i = 0; i < 10; i++) applyStimulus();

      // Asynchronous reset with records buffered and the output occupied.
      outReady = 1'b0;
      for (int i = 0; i < 3; i++) begin
         setIdle();
         setWrite(0, 32'h0000_C200 + 32'(i), 64'(32'h500 + i), 1'b1);
         applyStimulus();
      end
      setIdle();
      checkOutput("pre_rst_valid", {63'b0, outValid}, 64'd1);
      #2 reset = 1'b0;
      #1;
      modelReset();
      checkOutput("async_valid", {63'b0, outValid}, 64'd0);
      checkOutput("async_data",  outData,           64'd0);
      checkOutput("async_addr",  {32'b0, outAddr},  64'd0);
      checkOutput("async_cnt",   {48'b0, capCnt},   64'd0);
      @(negedge clk);
      applyStimulus();
      reset    = 1'b1;
      outReady = 1'b1;
      for (int i = 0; i < 4; i++) applyStimulus();

      // Random traffic concentrated around the window edges.
      for (int c = 0; c < 600; c++) begin
         for (int n = 0; n < 4; n++) begin
            case ($urandom_range(0, 5))
               0:       randAddr = 32'h0000_BFFF;
               1:       randAddr = 32'h0000_C000;
               2:       randAddr = 32'h0000_FFFF;
               3:       randAddr = 32'h0001_0000;
               4:       randAddr = $urandom;
               default: randAddr = WBASE + 32'($urandom_range(0, 32'h3FFF));
            endcase
            memEn[n]   = ($urandom_range(0, 9) < 4);
            memWrEn[n] = ($urandom_range(0, 3) != 0);
            addr[n]    = randAddr;
            data[n]    = {$urandom, $urandom};
         end
         outReady = ($urandom_range(0, 9) < 7);
         applyStimulus();
      end
      setIdle();
      outReady = 1'b1;
      for (int i = 0; i < 20; i++) applyStimulus();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/cmp_wb_collector.md
Name: cmp_wb_collector

Overview:
- Sits directly downstream of the 4-core CMP data-memory ports. It snoops each node's data-memory write traffic (memEn, memWrEn, addr, d_out).
- Captures writes that fall inside a programmable result window into per-node FIFOs.
- Drains the FIFOs round-robin onto one valid/ready record stream toward the host/off-chip logger.
- Non-intrusive: it never stalls or alters the processors or memories.

Parameters:
DATA_WIDTH, 64, width of node store data
ADDR_WIDTH, 32, width of node data address
FIFO_DEPTH, 4, entries per node FIFO (power of 2, >=2)
WIN_BASE, 32'h0000_C000, first captured address (inclusive)
WIN_LIMIT, 32'h0000_FFFF, last captured address (inclusive)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous active-low reset
nodeN_memEn  in  1  node N data-memory enable, N=0..3 (4 ports)
nodeN_memWrEn  in  1  node N write enable, N=0..3
nodeN_addr  in  ADDR_WIDTH  node N data address, N=0..3
nodeN_d  in  DATA_WIDTH  node N store data, N=0..3
out_valid  out  1  record available
out_ready  in  1  consumer accepts record
out_node  out  2  source node id of record
out_addr  out  ADDR_WIDTH  captured address
out_data  out  DATA_WIDTH  captured data
ovf  out  4  sticky per-node overflow flags
cap_cnt  out  16  total records captured (saturating)

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-low. While reset=0: all FIFOs empty, RR pointer=0, out_valid=0, out_node=0, out_addr=0, out_data=0, ovf=0, cap_cnt=0. Deassertion is synchronous to clk.
- Capture rule: node N's write is captured at a rising edge when memEn=1, memWrEn=1 and WIN_BASE<=addr<=WIN_LIMIT, comparison unsigned. Reads, and writes outside the window, are ignored.
- All 4 nodes may capture in the same cycle; each has its own FIFO, so no capture is lost unless that FIFO is full.
- Full FIFO: if node N's FIFO is full and no pop of N occurs that cycle, the new write is dropped and ovf[N] is set. ovf[N] stays set until reset. Push and pop of the same full FIFO in the same cycle: both happen, nothing is dropped, ovf is unchanged.
- cap_cnt: increments by the number of records actually enqueued that cycle (0..4). It saturates at 16'hFFFF.
- Output stage: a single registered record (out_valid/out_node/out_addr/out_data).
  - It loads when empty (out_valid=0) or being consumed (out_valid&out_ready).
  - It loads from the first non-empty FIFO at or after the RR pointer, searching upward modulo 4.
  - The RR pointer then becomes granted node+1 (mod 4).
  - If no FIFO is non-empty, out_valid deasserts on consumption.
- Handshake: transfer occurs when out_valid&out_ready at a rising edge. While out_valid=1 and out_ready=0, out_node/out_addr/out_data hold stable. out_valid never drops without a transfer.
- Latency: a write captured at edge k, into an empty system, appears with out_valid=1 after edge k+1. Sustained throughput is 1 record/cycle.
- Ordering: records from the same node leave in capture order. There is no ordering guarantee across nodes.
- Bypass: none. A capture always passes through its FIFO, including when the FIFO is empty.
- Reset mid-operation: all buffered records are discarded and no partial record is emitted.

Decomposition:
- Shared package/header holds DATA_WIDTH, ADDR_WIDTH, NODE_ID_WIDTH=2, NUM_NODES=4 and the record layout {node, addr, data}.
- Natural sub-module: cmp_wb_fifo, a synchronous single-clock FIFO with push, pop, full, empty and a count output. It is instantiated 4 times.
- Round-robin selection and the output register live in the top level.

Test Plan:
1. Reset: hold reset=0 while driving writes -> out_valid=0, ovf=0, cap_cnt=0. Release reset, then node2 writes addr C000 data 64'hDEAD -> one record {2, C000, DEAD} after 1 edge, cap_cnt=1.
2. Window filter: writes to BFFF, C000, FFFF, 10000 and a read of C004 -> only C000 and FFFF are captured. Records appear in order; cap_cnt=2.
3. Simultaneous: all 4 nodes write C000+N in one cycle with out_ready=1 -> node order 0,1,2,3 on 4 consecutive cycles. RR pointer ends at 0.
4. Backpressure/overflow: out_ready=0 and node1 issues 6 writes (DEPTH=4) -> 1 record in the output register, 4 in the FIFO, the 6th write is dropped, ovf=4'b0010. Output holds stable. Raise out_ready -> 5 records emerge in order.
5. Fairness: nodes 0 and 3 write continuously, out_ready=1 -> output alternates 0,3,0,3. Neither starves.
6. Mid-stream reset: assert reset with 3 records buffered and out_valid=1 -> outputs clear immediately (asynchronously). No stale record appears after release.
